// File: rtl/id_ex_stage_reg_if.sv
// ID/EX bundle: decoder controls and operands in, EX-side copies out.
// The DUT takes the slave view; the ID-side driver takes the master view.
interface id_ex_if #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [1:0]            id_ALUOp;
    logic                  id_Branch;
    logic                  id_MemRead;
    logic                  id_MemtoReg;
    logic                  id_MemWrite;
    logic                  id_ALUSrc;
    logic                  id_Regwrite;
    logic [DATA_W-1:0]     id_pc;
    logic [DATA_W-1:0]     id_rs1_data;
    logic [DATA_W-1:0]     id_rs2_data;
    logic [DATA_W-1:0]     id_imm;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [3:0]            id_funct;

    logic                  ex_valid;
    logic [1:0]            ex_ALUOp;
    logic                  ex_Branch;
    logic                  ex_MemRead;
    logic                  ex_MemtoReg;
    logic                  ex_MemWrite;
    logic                  ex_ALUSrc;
    logic                  ex_Regwrite;
    logic [DATA_W-1:0]     ex_pc;
    logic [DATA_W-1:0]     ex_rs1_data;
    logic [DATA_W-1:0]     ex_rs2_data;
    logic [DATA_W-1:0]     ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [3:0]            ex_funct;

    modport master (
        output id_valid, id_ALUOp, id_Branch, id_MemRead,
        output id_MemtoReg, id_MemWrite, id_ALUSrc, id_Regwrite,
        output id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1, id_rs2, id_rd, id_funct,
        input  ex_valid, ex_ALUOp, ex_Branch, ex_MemRead,
        input  ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_Regwrite,
        input  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd, ex_funct
    );

    modport slave (
        input  id_valid, id_ALUOp, id_Branch, id_MemRead,
        input  id_MemtoReg, id_MemWrite, id_ALUSrc, id_Regwrite,
        input  id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1, id_rs2, id_rd, id_funct,
        output ex_valid, ex_ALUOp, ex_Branch, ex_MemRead,
        output ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_Regwrite,
        output ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        output ex_rs1, ex_rs2, ex_rd, ex_funct
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Define ID_EX_PERF_EN to add bubble_count / flush_count counters.
module id_ex_stage_reg #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    id_ex_if.slave      bus,
    input  logic        flush,
    input  logic        hold,
`ifdef ID_EX_PERF_EN
    output logic [31:0] bubble_count,
    output logic [31:0] flush_count,
`endif
    output logic        hazard_stall
);

    typedef struct packed {
        logic                  valid;
        logic [1:0]            alu_op;
        logic                  branch;
        logic                  mem_read;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_write;
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     rs1_data;
        logic [DATA_W-1:0]     rs2_data;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [3:0]            funct;
    } ex_slot_t;

    ex_slot_t r_ex;
    ex_slot_t w_cap;
    logic     w_ex_load;
    logic     w_use_rs1;
    logic     w_use_rs2;
    logic     w_hz;
    logic     w_clear;

    // addi also raises MemRead, so a real load needs MemtoReg too
    assign w_ex_load = r_ex.valid & r_ex.mem_read & r_ex.mem_to_reg;
    assign w_use_rs1 = bus.id_valid;
    assign w_use_rs2 = bus.id_valid & (~bus.id_ALUSrc | bus.id_MemWrite);

    assign w_hz = w_ex_load && (r_ex.rd != '0) &&
                  ((w_use_rs1 && (r_ex.rd == bus.id_rs1)) ||
                   (w_use_rs2 && (r_ex.rd == bus.id_rs2)));

    assign hazard_stall = w_hz & ~flush;
    assign w_clear      = flush | (w_hz & ~hold);

    always_comb begin
        w_cap            = '0;
        w_cap.valid      = bus.id_valid;
        w_cap.pc         = bus.id_pc;
        w_cap.rs1_data   = bus.id_rs1_data;
        w_cap.rs2_data   = bus.id_rs2_data;
        w_cap.imm        = bus.id_imm;
        w_cap.rs1        = bus.id_rs1;
        w_cap.rs2        = bus.id_rs2;
        w_cap.rd         = bus.id_rd;
        w_cap.funct      = bus.id_funct;
        // gated so decoder don't-cares on stores/branches never leak
        if (bus.id_valid) begin
            w_cap.alu_op     = bus.id_ALUOp;
            w_cap.branch     = bus.id_Branch;
            w_cap.mem_read   = bus.id_MemRead;
            w_cap.mem_to_reg = bus.id_MemtoReg & bus.id_Regwrite;
            w_cap.mem_write  = bus.id_MemWrite;
            w_cap.alu_src    = bus.id_ALUSrc;
            w_cap.reg_write  = bus.id_Regwrite;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex <= '0;
        end else if (w_clear) begin
            r_ex <= '0;
        end else if (!hold) begin
            r_ex <= w_cap;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_hz && !flush && !hold)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (flush)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign bubble_count = r_bubble_cnt;
    assign flush_count  = r_flush_cnt;
`endif

    assign bus.ex_valid    = r_ex.valid;
    assign bus.ex_ALUOp    = r_ex.alu_op;
    assign bus.ex_Branch   = r_ex.branch;
    assign bus.ex_MemRead  = r_ex.mem_read;
    assign bus.ex_MemtoReg = r_ex.mem_to_reg;
    assign bus.ex_MemWrite = r_ex.mem_write;
    assign bus.ex_ALUSrc   = r_ex.alu_src;
    assign bus.ex_Regwrite = r_ex.reg_write;
    assign bus.ex_pc       = r_ex.pc;
    assign bus.ex_rs1_data = r_ex.rs1_data;
    assign bus.ex_rs2_data = r_ex.rs2_data;
    assign bus.ex_imm      = r_ex.imm;
    assign bus.ex_rs1      = r_ex.rs1;
    assign bus.ex_rs2      = r_ex.rs2;
    assign bus.ex_rd       = r_ex.rd;
    assign bus.ex_funct    = r_ex.funct;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed pipeline cases, then
// random traffic checked against a rule-level model of the EX slot.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [1:0]  alu_op;
        logic        branch, mem_read, mem_to_reg;
        logic        mem_write, alu_src, reg_write;
        logic [63:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  funct;
    } slot_t;

    typedef struct {
        slot_t ins;
        logic  flush;
        logic  hold;
    } stim_t;

    logic clk = 0;
    logic reset_n = 0;
    logic flush = 0;
    logic hold = 0;
    logic hazard_stall;

    id_ex_if #(.DATA_W(64), .REG_ADDR_W(5)) bus ();

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_count, flush_count;
    int unsigned exp_bubbles = 0, exp_flushes = 0;
`endif

    id_ex_stage_reg #(.DATA_W(64), .REG_ADDR_W(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus.slave),
        .flush        (flush),
        .hold         (hold),
`ifdef ID_EX_PERF_EN
        .bubble_count (bubble_count),
        .flush_count  (flush_count),
`endif
        .hazard_stall (hazard_stall)
    );

    always #5 clk = ~clk;

    int    n_pass = 0, n_total = 0;
    slot_t m = '0;
    logic  q_hs[$];
    slot_t q_ex[$];

    function automatic void chk(string nm, logic [287:0] got, logic [287:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    endfunction

    function automatic slot_t dut_slot();
        slot_t s;
        s.valid = bus.ex_valid;       s.alu_op = bus.ex_ALUOp;
        s.branch = bus.ex_Branch;     s.mem_read = bus.ex_MemRead;
        s.mem_to_reg = bus.ex_MemtoReg;
        s.mem_write = bus.ex_MemWrite; s.alu_src = bus.ex_ALUSrc;
        s.reg_write = bus.ex_Regwrite; s.pc = bus.ex_pc;
        s.rs1_data = bus.ex_rs1_data; s.rs2_data = bus.ex_rs2_data;
        s.imm = bus.ex_imm;           s.rs1 = bus.ex_rs1;
        s.rs2 = bus.ex_rs2;           s.rd = bus.ex_rd;
        s.funct = bus.ex_funct;
        return s;
    endfunction

    // Reference: is the ID instruction reading a register a load in EX writes?
    function automatic logic model_hz(slot_t ex, slot_t id);
        logic is_load, reads2;
        is_load = ex.valid && ex.mem_read && ex.mem_to_reg && ex.rd != 0;
        reads2  = id.valid && (!id.alu_src || id.mem_write);
        return is_load && ((id.valid && id.rs1 == ex.rd) ||
                           (reads2 && id.rs2 == ex.rd));
    endfunction

    function automatic slot_t model_next(slot_t ex, stim_t s);
        slot_t n;
        if (s.flush) return '0;
        if (s.hold) return ex;
        if (model_hz(ex, s.ins)) return '0;
        n = s.ins;
        if (!n.valid) begin
            n.alu_op = 0; n.branch = 0; n.mem_read = 0; n.mem_to_reg = 0;
            n.mem_write = 0; n.alu_src = 0; n.reg_write = 0;
        end
        if (!n.reg_write) n.mem_to_reg = 0;
        return n;
    endfunction

    task automatic drive(stim_t s);
        bus.id_valid = s.ins.valid;       bus.id_ALUOp = s.ins.alu_op;
        bus.id_Branch = s.ins.branch;     bus.id_MemRead = s.ins.mem_read;
        bus.id_MemtoReg = s.ins.mem_to_reg;
        bus.id_MemWrite = s.ins.mem_write; bus.id_ALUSrc = s.ins.alu_src;
        bus.id_Regwrite = s.ins.reg_write; bus.id_pc = s.ins.pc;
        bus.id_rs1_data = s.ins.rs1_data; bus.id_rs2_data = s.ins.rs2_data;
        bus.id_imm = s.ins.imm;           bus.id_rs1 = s.ins.rs1;
        bus.id_rs2 = s.ins.rs2;           bus.id_rd = s.ins.rd;
        bus.id_funct = s.ins.funct;
        flush = s.flush;
        hold = s.hold;
    endtask

    // One cycle: drive at negedge, queue the expected stall and EX slot.
    task automatic step(stim_t s, int want_hs);
        logic h;
        @(negedge clk);
        drive(s);
        #1;
        h = model_hz(m, s.ins) && !s.flush;
        q_hs.push_back(h);
        if (want_hs >= 0) chk("hs_directed", hazard_stall, want_hs[0]);
`ifdef ID_EX_PERF_EN
        if (h && !s.hold) exp_bubbles++;
        if (s.flush) exp_flushes++;
`endif
        m = model_next(m, s);
        q_ex.push_back(m);
    endtask

    function automatic stim_t mk(slot_t i);
        stim_t s;
        s.ins = i; s.flush = 0; s.hold = 0;
        return s;
    endfunction

    function automatic slot_t base(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        slot_t i = '0;
        i.valid = 1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        i.pc = 64'h1000 + {rd, 2'b00};
        return i;
    endfunction

    function automatic slot_t r_add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        slot_t i = base(rd, rs1, rs2);
        i.alu_op = 2'b10; i.reg_write = 1;
        i.rs1_data = 64'h10; i.rs2_data = 64'h20;
        return i;
    endfunction

    function automatic slot_t ld(logic [4:0] rd, logic [4:0] rs1);
        slot_t i = base(rd, rs1, 5'd0);
        i.mem_read = 1; i.mem_to_reg = 1; i.alu_src = 1; i.reg_write = 1;
        i.imm = 64'h8; i.funct = 4'b0011;
        return i;
    endfunction

    function automatic slot_t addi(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        slot_t i = base(rd, rs1, rs2);
        i.mem_read = 1; i.alu_src = 1; i.reg_write = 1; i.imm = 64'h4;
        return i;
    endfunction

    // MemtoReg=1 stands in for the decoder's don't-care on stores
    function automatic slot_t sd(logic [4:0] rs2, logic [4:0] rs1);
        slot_t i = base(5'd0, rs1, rs2);
        i.mem_write = 1; i.alu_src = 1; i.mem_to_reg = 1; i.funct = 4'b0011;
        return i;
    endfunction

    function automatic slot_t beq(logic [4:0] rs1, logic [4:0] rs2);
        slot_t i = base(5'd0, rs1, rs2);
        i.branch = 1; i.alu_op = 2'b01; i.mem_to_reg = 1;
        return i;
    endfunction

    function automatic slot_t rnd_ins();
        slot_t i;
        logic [4:0] rd = 5'($urandom_range(0, 3));
        logic [4:0] r1 = 5'($urandom_range(0, 3));
        logic [4:0] r2 = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
            0: i = r_add(rd, r1, r2);
            1, 2: i = ld(rd, r1);
            3: i = addi(rd, r1, r2);
            4: i = sd(r2, r1);
            default: i = beq(r1, r2);
        endcase
        i.pc = {$urandom, $urandom};
        i.rs1_data = {$urandom, $urandom};
        i.rs2_data = {$urandom, $urandom};
        i.imm = {$urandom, $urandom};
        i.funct = 4'($urandom);
        if ($urandom_range(0, 7) == 0) i.valid = 0;
        return i;
    endfunction

    initial begin : monitor_hs
        forever begin
            @(negedge clk);
            #2;
            if (q_hs.size() > 0) chk("hazard_stall", hazard_stall, q_hs.pop_front());
        end
    end

    initial begin : monitor_ex
        forever begin
            @(posedge clk);
            #1;
            if (q_ex.size() > 0) chk("ex_slot", dut_slot(), q_ex.pop_front());
        end
    end

    initial begin : stimulus
        stim_t s;
        logic  last_hs;
        drive(mk('0));
        repeat (2) @(negedge clk);
        chk("reset_slot", dut_slot(), '0);
        chk("reset_hs", hazard_stall, 1'b0);
        reset_n = 1;

        step(mk(r_add(5, 1, 2)), 0);
        @(posedge clk);
        #1;
        chk("add_alu_op", bus.ex_ALUOp, 2'b10);
        chk("add_rd", bus.ex_rd, 5'd5);
        chk("add_rs2_data", bus.ex_rs2_data, 64'h20);
        #2 reset_n = 0;
        #1;
        chk("async_reset_slot", dut_slot(), '0);
        chk("async_reset_valid", bus.ex_valid, 1'b0);
        m = '0;
        #1 reset_n = 1;
        step(mk('0), 0);
        step(mk('0), 0);

        step(mk(ld(6, 2)), 0);
        step(mk(r_add(7, 6, 1)), 1);
        step(mk(r_add(7, 6, 1)), 0);
        step(mk(ld(0, 2)), 0);
        step(mk(r_add(7, 0, 0)), 0);
        step(mk(addi(6, 1, 0)), 0);
        step(mk(r_add(7, 6, 6)), 0);
        step(mk(ld(6, 2)), 0);
        step(mk(addi(8, 9, 6)), 0);
        step(mk(ld(6, 2)), 0);
        step(mk(sd(6, 2)), 1);
        step(mk(sd(6, 2)), 0);
        step(mk(beq(3, 4)), 0);
        step(mk(ld(6, 2)), 0);
        s = mk(r_add(7, 6, 1));
        s.hold = 1;
        step(s, 1);
        s.hold = 0;
        s.flush = 1;
        step(s, 0);
        step(mk(ld(6, 2)), 0);
        step(mk(r_add(7, 1, 6)), 1);
        s = mk(r_add(7, 1, 6));
        s.flush = 1;
        step(s, 0);
        step(mk(ld(5, 2)), 0);
        step(mk(r_add(9, 5, 5)), 1);
        step(mk(r_add(9, 5, 5)), 0);

        last_hs = 0;
        s = mk(rnd_ins());
        for (int n = 0; n < 500; n++) begin
            if (!last_hs) s.ins = rnd_ins();
            s.flush = ($urandom_range(0, 9) == 0);
            s.hold = ($urandom_range(0, 6) == 0);
            last_hs = model_hz(m, s.ins) && !s.flush;
            step(s, -1);
        end

        s = mk('0);
        step(s, -1);
        repeat (2) @(negedge clk);
        chk("queues_drained", 288'(q_hs.size() + q_ex.size()), 288'd0);
`ifdef ID_EX_PERF_EN
        chk("bubble_count", bubble_count, exp_bubbles);
        chk("flush_count", flush_count, exp_flushes);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
